// File: rtl/display_pkg.sv
// Shared constants, FSM state type and digit-search helper for the 7-segment scan controller.
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  // Circular priority search: first enabled digit after cur; cur itself is the last candidate.
  function automatic logic [1:0] next_digit(input logic [NUM_DIGITS-1:0] mask,
                                            input logic [1:0]            cur);
    logic [1:0] idx;
    next_digit = cur;
    for (int k = NUM_DIGITS; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (mask[idx]) begin
        next_digit = idx;
      end else begin
        next_digit = next_digit;
      end
    end
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-slot prescaler: counts 0..PRESCALE-1, flags the last cycle of blanking and of the slot.
module slot_timer
  import display_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic tc_o,
  output logic blank_done_o
);

  localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? (BLANK - 1) : 0);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o         = (cnt_q == CNT_LAST);
  assign blank_done_o = (BLANK > 0) && (cnt_q == BLANK_LAST);

  // Next count: clear wins, terminal count wraps to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tc_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_mux_ctrl.sv
// 4-digit 7-segment scan controller with mask skipping and optional blanking dead-time.
// Blanking is built only when DISPLAY_MUX_BLANK_EN is defined.
module display_mux_ctrl
  import display_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 500
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_i,
  input  logic [NUM_DIGITS-1:0]       digit_mask_i,
  input  logic [NUM_DIGITS*SEG_W-1:0] segs_i,
  output logic [NUM_DIGITS-1:0]       digit_sel_o,
  output logic [SEG_W-1:0]            seg_out_o,
  output logic [1:0]                  slot_o,
  output logic                        frame_tick_o
);

`ifdef DISPLAY_MUX_BLANK_EN
  localparam bit USE_BLANK = (BLANK > 0);
`else
  localparam bit USE_BLANK = 1'b0;
`endif

  localparam state_e SLOT_START = USE_BLANK ? ST_BLANK : ST_SHOW;

  state_e                  state_q, state_d;
  logic [1:0]              slot_q, slot_d;
  logic [1:0]              nxt_slot;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic [SEG_W-1:0]        seg_out_q, seg_out_d;
  logic                    frame_tick_q, frame_tick_d;
  logic                    go_idle;
  logic                    lit;
  logic                    tc;
  logic                    blank_done;

  assign go_idle = !en_i || (digit_mask_i == '0);

  slot_timer #(
    .PRESCALE (PRESCALE),
    .BLANK    (USE_BLANK ? BLANK : 0)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (go_idle || (state_q == ST_IDLE)),
    .tc_o         (tc),
    .blank_done_o (blank_done)
  );

  // Next state, slot selection and the registered output values derived from them.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    frame_tick_d = 1'b0;
    nxt_slot     = next_digit(digit_mask_i, slot_q);
    if (go_idle) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          slot_d  = next_digit(digit_mask_i, 2'd3);
          state_d = SLOT_START;
        end
`ifdef DISPLAY_MUX_BLANK_EN
        ST_BLANK: begin
          if (blank_done) begin
            state_d = ST_SHOW;
          end else begin
            state_d = ST_BLANK;
          end
        end
`endif
        ST_SHOW: begin
          if (tc) begin
            slot_d       = nxt_slot;
            frame_tick_d = (nxt_slot <= slot_q);
            state_d      = SLOT_START;
          end else begin
            state_d = ST_SHOW;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // A digit whose mask bit has dropped stays dark for the rest of its slot.
    lit = (state_d == ST_SHOW) && digit_mask_i[slot_d];
    if (lit) begin
      digit_sel_d = 4'b0001 << slot_d;
      seg_out_d   = segs_i[int'(slot_d)*SEG_W +: SEG_W];
    end else begin
      digit_sel_d = '0;
      seg_out_d   = '0;
    end
  end

  // State, slot and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      slot_q       <= 2'd0;
      digit_sel_q  <= '0;
      seg_out_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      digit_sel_q  <= digit_sel_d;
      seg_out_q    <= seg_out_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign digit_sel_o  = digit_sel_q;
  assign seg_out_o    = seg_out_q;
  assign slot_o       = slot_q;
  assign frame_tick_o = frame_tick_q;

endmodule
